// File: rtl/rf_writeback_if.sv
// rf_writeback_if: bundles the producer handshakes, the register-file write
// port, the pending scoreboard and the forwarding lookup of rf_writeback.
//   master : the rf_writeback side (drives ready, write port, scoreboard, fwd)
//   slave  : the environment (ALU/load producers, register file, decode)
interface rf_writeback_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_tgt;
  logic [15:0] ld_val;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_tgt;
  logic [15:0] alu_val;
  logic        we_rf;
  logic [2:0]  tgt;
  logic [15:0] tgt_val;
  logic [7:0]  pending;
  logic        empty;
  logic [2:0]  fwd_src1;
  logic [2:0]  fwd_src2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [15:0] fwd1_val;
  logic [15:0] fwd2_val;

  modport master (
    input  ld_valid, ld_tgt, ld_val, alu_valid, alu_tgt, alu_val,
           fwd_src1, fwd_src2,
    output ld_ready, alu_ready, we_rf, tgt, tgt_val, pending, empty,
           fwd1_hit, fwd2_hit, fwd1_val, fwd2_val
  );

  modport slave (
    output ld_valid, ld_tgt, ld_val, alu_valid, alu_tgt, alu_val,
           fwd_src1, fwd_src2,
    input  ld_ready, alu_ready, we_rf, tgt, tgt_val, pending, empty,
           fwd1_hit, fwd2_hit, fwd1_val, fwd2_val
  );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: write-side initiator for the 8x16 register file.
// Load and ALU results are queued in a DEPTH-entry circular buffer and drained
// one entry per cycle onto we_rf/tgt/tgt_val (latched by the RF at negedge).
// Writes to r0 complete their handshake but are dropped.
//
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - rf_writeback_if.master: ld_*/alu_* producer handshakes, RF write
//          port, pending scoreboard, empty flag, forwarding lookup
//
// Optional feature: define RF_WB_FORWARD_EN to enable the forwarding lookup
// (fwdN_hit / fwdN_val). Without it the lookup outputs are tied to zero.
module rf_writeback #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_writeback_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    r_mem_tgt [DEPTH];
  logic [15:0]   r_mem_val [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [2:0]    r_tgt;
  logic [15:0]   r_tgt_val;

  logic          w_full;
  logic          w_ld_xfer;
  logic          w_alu_xfer;
  logic [2:0]    w_in_tgt;
  logic [15:0]   w_in_val;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_remain;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_head_nxt;
  logic          w_we_nxt;
  logic [2:0]    w_tgt_nxt;
  logic [15:0]   w_val_nxt;
  logic [7:0]    w_pending;
  logic [AW-1:0] w_idx;

  // The drain runs every cycle, so full only guards the buffer if that ever
  // changes; it deliberately ignores a same-cycle pop.
  assign w_full        = (r_count == CW'(DEPTH));
  assign bus.ld_ready  = !w_full;
  assign bus.alu_ready = !w_full && !bus.ld_valid;

  assign w_ld_xfer  = bus.ld_valid && bus.ld_ready;
  assign w_alu_xfer = bus.alu_valid && bus.alu_ready;
  assign w_in_tgt   = w_ld_xfer ? bus.ld_tgt : bus.alu_tgt;
  assign w_in_val   = w_ld_xfer ? bus.ld_val : bus.alu_val;
  assign w_push     = (w_ld_xfer || w_alu_xfer) && (w_in_tgt != 3'd0);
  assign w_pop      = (r_count != '0);

  // The output registers are loaded with whatever will be the head after this
  // edge. If no older entry survives the pop, that head is the incoming one.
  always_comb begin
    w_remain    = r_count - CW'(w_pop);
    w_count_nxt = w_remain + CW'(w_push);
    w_head_nxt  = r_head + AW'(w_pop);
    w_we_nxt    = (w_count_nxt != '0);
    w_tgt_nxt   = 3'd0;
    w_val_nxt   = 16'h0000;
    if (w_we_nxt) begin
      if (w_remain == '0) begin
        w_tgt_nxt = w_in_tgt;
        w_val_nxt = w_in_val;
      end else begin
        w_tgt_nxt = r_mem_tgt[w_head_nxt];
        w_val_nxt = r_mem_val[w_head_nxt];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_tgt     <= 3'd0;
      r_tgt_val <= 16'h0000;
    end else begin
      r_head    <= w_head_nxt;
      r_tail    <= r_tail + AW'(w_push);
      r_count   <= w_count_nxt;
      r_we      <= w_we_nxt;
      r_tgt     <= w_tgt_nxt;
      r_tgt_val <= w_val_nxt;
    end
  end

  // Storage needs no reset: only entries inside the head/count window are read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_tgt[r_tail] <= w_in_tgt;
      r_mem_val[r_tail] <= w_in_val;
    end
  end

  always_comb begin
    w_pending = 8'h00;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if (CW'(k) < r_count) w_pending[r_mem_tgt[w_idx]] = 1'b1;
    end
    w_pending[0] = 1'b0;
  end

  assign bus.we_rf   = r_we;
  assign bus.tgt     = r_tgt;
  assign bus.tgt_val = r_tgt_val;
  assign bus.pending = w_pending;
  assign bus.empty   = (r_count == '0);

`ifdef RF_WB_FORWARD_EN
  logic          w_f1_hit;
  logic          w_f2_hit;
  logic [15:0]   w_f1_val;
  logic [15:0]   w_f2_val;
  logic [AW-1:0] w_fidx;

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_f1_hit = 1'b0;
    w_f2_hit = 1'b0;
    w_f1_val = 16'h0000;
    w_f2_val = 16'h0000;
    w_fidx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_fidx = r_head + AW'(k);
      if (CW'(k) < r_count) begin
        if (bus.fwd_src1 != 3'd0 && r_mem_tgt[w_fidx] == bus.fwd_src1) begin
          w_f1_hit = 1'b1;
          w_f1_val = r_mem_val[w_fidx];
        end
        if (bus.fwd_src2 != 3'd0 && r_mem_tgt[w_fidx] == bus.fwd_src2) begin
          w_f2_hit = 1'b1;
          w_f2_val = r_mem_val[w_fidx];
        end
      end
    end
  end

  assign bus.fwd1_hit = w_f1_hit;
  assign bus.fwd2_hit = w_f2_hit;
  assign bus.fwd1_val = w_f1_val;
  assign bus.fwd2_val = w_f2_val;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.fwd_src1, bus.fwd_src2};
  assign bus.fwd1_hit = 1'b0;
  assign bus.fwd2_hit = 1'b0;
  assign bus.fwd1_val = 16'h0000;
  assign bus.fwd2_val = 16'h0000;
`endif
endmodule
